// File: rtl/transmissor_caractere_pkg.sv
// Shared definitions for the character serial link (transmitter now, receiver later).
package pkg_caractere;
    localparam int BITS_QUADRO = 8;
    localparam int BITS_DADOS  = 5;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

    // Even parity over data plus parity bit; inverte forces a deliberate parity error.
    function automatic logic paridade_par(input logic [BITS_DADOS-1:0] dados, input logic inverte);
        return (^dados) ^ inverte;
    endfunction
endpackage

// File: rtl/transmissor_caractere_tick.sv
// Bit-period counter: counts 0..CLKS_POR_BIT-1 while enabled, held at 0 otherwise.
module gerador_tick #(
    parameter int CLKS_POR_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic habilita,
    output logic tick
);
    localparam int LARG = $clog2(CLKS_POR_BIT);
    localparam logic [LARG-1:0] ULTIMO = LARG'(CLKS_POR_BIT - 1);

    logic [LARG-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !habilita)
            r_cnt <= '0;
        else if (r_cnt == ULTIMO)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = habilita && (r_cnt == ULTIMO);
endmodule

// File: rtl/transmissor_caractere.sv
// Serial transmitter for 5-bit character codes: start, 5 data bits LSB first, parity, stop.
//   state    | meaning
//   OCIOSO   | idle, tx = 1, ready for a request
//   INICIO   | start bit (0)
//   DADOS    | data bits char[0]..char[4]
//   PARIDADE | parity bit (optionally forced wrong)
//   PARADA   | stop bit (1), fim on its last cycle
module transmissor_caractere
    import pkg_caractere::*;
#(
    parameter int CLKS_POR_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITS_DADOS-1:0] char,
    input  logic                  envia,
    input  logic                  erro_forcado,
    output logic                  pronto,
    output logic                  tx,
    output logic                  ocupado,
    output logic                  fim
);
    localparam logic [2:0] ULTIMO_INDICE = 3'(BITS_DADOS - 1);

    estado_t               r_estado;
    estado_t               w_prox_estado;
    logic [BITS_DADOS-1:0] r_char;
    logic                  r_erro;
    logic [2:0]            r_indice;
    logic [2:0]            w_indice_seg;
    logic                  r_tx;
    logic                  w_tx_prox;
    logic                  w_tick;
    logic                  w_aceita;
    logic                  w_habilita;

    assign w_aceita     = envia && (r_estado == OCIOSO);
    assign w_habilita   = (r_estado != OCIOSO);
    assign w_indice_seg = r_indice + 3'd1;

    gerador_tick #(.CLKS_POR_BIT(CLKS_POR_BIT)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .habilita (w_habilita),
        .tick     (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_estado <= OCIOSO;
        else
            r_estado <= w_prox_estado;
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO:   if (w_aceita) w_prox_estado = INICIO;
            INICIO:   if (w_tick) w_prox_estado = DADOS;
            DADOS:    if (w_tick && r_indice == ULTIMO_INDICE) w_prox_estado = PARIDADE;
            PARIDADE: if (w_tick) w_prox_estado = PARADA;
            PARADA:   if (w_tick) w_prox_estado = OCIOSO;
            default:  w_prox_estado = OCIOSO;
        endcase
    end

    // w_tx_prox is the level tx takes after this edge, so tx itself is a plain flop.
    always_comb begin
        pronto    = (r_estado == OCIOSO);
        ocupado   = (r_estado != OCIOSO);
        fim       = (r_estado == PARADA) && w_tick;
        w_tx_prox = r_tx;
        case (r_estado)
            OCIOSO:   w_tx_prox = !w_aceita;
            INICIO:   if (w_tick) w_tx_prox = r_char[0];
            DADOS:    if (w_tick) w_tx_prox = (r_indice == ULTIMO_INDICE) ?
                                              paridade_par(r_char, r_erro) : r_char[w_indice_seg];
            PARIDADE: if (w_tick) w_tx_prox = 1'b1;
            default:  w_tx_prox = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx     <= 1'b1;
            r_char   <= '0;
            r_erro   <= 1'b0;
            r_indice <= '0;
        end else begin
            r_tx <= w_tx_prox;
            if (w_aceita) begin
                r_char <= char;
                r_erro <= erro_forcado;
            end
            if (r_estado == INICIO && w_tick)
                r_indice <= '0;
            else if (r_estado == DADOS && w_tick && r_indice != ULTIMO_INDICE)
                r_indice <= w_indice_seg;
        end
    end

    assign tx = r_tx;
endmodule

// File: tb/tb_transmissor_caractere.sv
// Randomized self-checking bench; expected tx comes from a frame array built from the char rules.
module tb_transmissor_caractere;
    import pkg_caractere::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] char_in;
    logic       erro_in;
    logic       envia_a, envia_b;
    logic       pronto_a, tx_a, ocupado_a, fim_a;
    logic       pronto_b, tx_b, ocupado_b, fim_b;
    int         n_testes = 0;
    int         n_falhas = 0;

    always #5 clk = ~clk;

    transmissor_caractere #(.CLKS_POR_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .char(char_in), .envia(envia_a), .erro_forcado(erro_in),
        .pronto(pronto_a), .tx(tx_a), .ocupado(ocupado_a), .fim(fim_a)
    );

    transmissor_caractere #(.CLKS_POR_BIT(2)) dut_b (
        .clk(clk), .rst(rst), .char(char_in), .envia(envia_b), .erro_forcado(erro_in),
        .pronto(pronto_b), .tx(tx_b), .ocupado(ocupado_b), .fim(fim_b)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido %0h esperado %0h @%0t", tag, obs, esp, $time);
        end
    endtask

    // Frame as seen on the line, position 0 = start bit.
    function automatic logic bit_esperado(input logic [4:0] c, input logic e, input int pos);
        logic quadro [BITS_QUADRO];
        int   uns;
        uns = 0;
        quadro[0] = 1'b0;
        for (int i = 0; i < BITS_DADOS; i++) begin
            quadro[i+1] = c[i];
            if (c[i]) uns++;
        end
        quadro[6] = ((uns % 2) == 1) ? !e : e;
        quadro[7] = 1'b1;
        return quadro[pos];
    endfunction

    function automatic logic s_tx(input int sel);      return sel ? tx_b : tx_a;           endfunction
    function automatic logic s_pronto(input int sel);  return sel ? pronto_b : pronto_a;   endfunction
    function automatic logic s_ocupado(input int sel); return sel ? ocupado_b : ocupado_a; endfunction
    function automatic logic s_fim(input int sel);     return sel ? fim_b : fim_a;         endfunction

    task automatic poe_envia(input int sel, input logic v);
        if (sel != 0) envia_b = v;
        else          envia_a = v;
    endtask

    task automatic ocioso(input int ciclos);
        for (int i = 0; i < ciclos; i++) begin
            verifica("ocioso_tx_a", tx_a, 1);
            verifica("ocioso_pronto_a", pronto_a, 1);
            verifica("ocioso_ocupado_a", ocupado_a, 0);
            verifica("ocioso_fim_a", fim_a, 0);
            verifica("ocioso_tx_b", tx_b, 1);
            verifica("ocioso_pronto_b", pronto_b, 1);
            verifica("ocioso_ocupado_b", ocupado_b, 0);
            verifica("ocioso_fim_b", fim_b, 0);
            @(negedge clk);
        end
    endtask

    // Called on a negedge with the selected DUT idle; returns on the first idle cycle after the frame.
    task automatic envia_quadro(input int sel, input logic [4:0] c, input logic e, input bit mantem);
        int n;
        n = (sel != 0) ? 2 : 4;
        verifica("pronto_antes", s_pronto(sel), 1);
        char_in = c;
        erro_in = e;
        poe_envia(sel, 1'b1);
        @(negedge clk);
        if (!mantem) poe_envia(sel, 1'b0);
        for (int k = 1; k <= 8 * n; k++) begin
            verifica("tx_quadro", s_tx(sel), bit_esperado(c, e, (k - 1) / n));
            verifica("fim_quadro", s_fim(sel), (k == 8 * n));
            verifica("pronto_quadro", s_pronto(sel), 0);
            verifica("ocupado_quadro", s_ocupado(sel), 1);
            char_in = 5'($urandom);
            erro_in = 1'($urandom);
            @(negedge clk);
        end
        verifica("pronto_apos", s_pronto(sel), 1);
        verifica("tx_entre_quadros", s_tx(sel), 1);
        verifica("fim_apos", s_fim(sel), 0);
    endtask

    initial begin
        logic [4:0] c;
        logic       e;
        int         sel;

        rst     = 1'b1;
        envia_a = 1'b1;
        envia_b = 1'b1;
        char_in = 5'b00011;
        erro_in = 1'b0;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        envia_a = 1'b0;
        envia_b = 1'b0;
        ocioso(10);

        envia_quadro(0, 5'b00011, 1'b0, 1'b0);
        ocioso(2);
        envia_quadro(0, 5'b00011, 1'b1, 1'b0);
        ocioso(1);

        envia_quadro(0, 5'b10011, 1'b0, 1'b1);
        envia_quadro(0, 5'b10011, 1'b0, 1'b1);
        envia_quadro(0, 5'b10011, 1'b0, 1'b0);
        ocioso(1);

        // Abort in the middle of data bit 2 (frame position 3).
        verifica("pronto_antes_reset", pronto_a, 1);
        char_in = 5'b10101;
        erro_in = 1'b0;
        envia_a = 1'b1;
        @(negedge clk);
        envia_a = 1'b0;
        for (int k = 1; k < 3 * 4 + 2; k++) @(negedge clk);
        verifica("tx_bit2_antes_reset", tx_a, bit_esperado(5'b10101, 1'b0, 3));
        rst = 1'b1;
        @(negedge clk);
        verifica("tx_apos_reset", tx_a, 1);
        verifica("pronto_apos_reset", pronto_a, 1);
        verifica("ocupado_apos_reset", ocupado_a, 0);
        verifica("fim_apos_reset", fim_a, 0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            verifica("sem_fim_apos_abort", fim_a, 0);
            verifica("sem_retomada_tx", tx_a, 1);
            @(negedge clk);
        end
        envia_quadro(0, 5'b01101, 1'b0, 1'b0);

        envia_quadro(1, 5'b00000, 1'b0, 1'b0);
        ocioso(1);
        envia_quadro(0, 5'd31, 1'b0, 1'b0);
        envia_quadro(1, 5'd20, 1'b1, 1'b0);

        for (int it = 0; it < 30; it++) begin
            sel = int'($urandom_range(0, 1));
            c   = 5'($urandom);
            e   = ($urandom_range(0, 3) == 0);
            envia_quadro(sel, c, e, 1'b0);
            ocioso(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end
endmodule

// File: doc/transmissor_caractere.md
TRANSMISSOR_CARACTERE -- requirements
Module: transmissor_caractere

Interface
REQ-001 The block SHALL have parameter CLKS_POR_BIT, default 4, meaning clock cycles per serial bit (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port char, input, 5 bits: character code E1-E5 to send, with E1 = char[0].
REQ-005 The block SHALL have port envia, input, 1 bit: request valid; char and erro_forcado are sampled when envia and pronto are both high.
REQ-006 The block SHALL have port erro_forcado, input, 1 bit: when sampled high, the block inverts the transmitted parity bit (error-glyph test).
REQ-007 The block SHALL have port pronto, output, 1 bit: ready; high only in state OCIOSO.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line; idle level 1.
REQ-009 The block SHALL have port ocupado, output, 1 bit: high in every state except OCIOSO.
REQ-010 The block SHALL have port fim, output, 1 bit: one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 The frame SHALL be 8 bits, in order: start (0), char[0]..char[4] (LSB first), parity, stop (1); each bit SHALL be held on tx for exactly CLKS_POR_BIT cycles.
REQ-012 Parity SHALL be even over the 5 data bits plus parity (parity = XOR of char), inverted when the captured erro_forcado = 1.
REQ-013 The FSM SHALL have the states OCIOSO, INICIO, DADOS, PARIDADE and PARADA, with transitions OCIOSO->INICIO on acceptance, and INICIO->DADOS, DADOS->PARIDADE after bit index 4, PARIDADE->PARADA and PARADA->OCIOSO, each on the bit-period end tick.
REQ-014 On acceptance, the block SHALL capture char and erro_forcado into internal registers, and tx SHALL go to 0 on the following cycle; the captured values SHALL be used for the entire frame, and input changes during a frame SHALL be ignored.
REQ-015 Latency SHALL be 1 cycle from the accepting edge to the start bit on tx; the total frame SHALL be 8*CLKS_POR_BIT cycles.
REQ-016 envia asserted while pronto = 0 SHALL be ignored and not queued; the requester SHALL hold envia until acceptance.
REQ-017 The bit-period counter SHALL count 0..CLKS_POR_BIT-1 and wrap to 0; the end tick SHALL occur at count CLKS_POR_BIT-1; the counter SHALL be held at 0 in OCIOSO.
REQ-018 The bit index SHALL count 0..4 in DADOS only and SHALL be cleared on entry to DADOS.
REQ-019 fim SHALL be asserted in the same cycle as the PARADA->OCIOSO end tick; the next cycle SHALL be OCIOSO with pronto = 1, so that back-to-back frames have at least one idle cycle with tx = 1 between stop and start.
REQ-020 Codes 20..31 SHALL be transmitted unchanged, with no range checking in this block.
REQ-021 tx SHALL be driven directly from a register, with no combinational glitches.

Reset
REQ-022 While rst = 1 at a clock edge, the next state SHALL be: state OCIOSO, tx = 1, pronto = 1, ocupado = 0, fim = 0, counters 0 and capture registers 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame: tx = 1 from the next edge, no fim pulse, and no resumption after release.
REQ-024 envia high during the reset cycle SHALL NOT be accepted; acceptance is possible only from the first cycle with rst = 0.

Structure
REQ-025 The state enumeration, frame length (8) and data width (5) SHALL be defined in a shared package pkg_caractere, reused by the future receiver.
REQ-026 The bit-period counter SHALL be implemented as one sub-module, gerador_tick (inputs: clk, rst, habilita; output: tick), parameterised by CLKS_POR_BIT.

Verification
REQ-027 The bench SHALL cover: reset, then idle for 10 cycles -> tx = 1, pronto = 1, ocupado = 0, fim = 0 throughout.
REQ-028 The bench SHALL cover: CLKS_POR_BIT = 4, char = 5'b00011, erro_forcado = 0, envia for 1 cycle -> tx sequence 0,1,1,0,0,0,0,1, each bit 4 cycles; fim high in cycle 32 after acceptance; pronto high in cycle 33.
REQ-029 The bench SHALL cover: char = 5'b00011 with erro_forcado = 1 -> identical frame except parity bit = 1.
REQ-030 The bench SHALL cover: envia held high continuously with char = 5'b10011 -> repeated frames 0,1,1,0,0,1,1,1, separated by exactly one idle cycle at tx = 1; changing char mid-frame does not alter the current frame.
REQ-031 The bench SHALL cover: rst pulsed during data bit 2 -> tx = 1 on the next cycle, no fim pulse, pronto = 1 after release, and the next request is sent correctly.
REQ-032 The bench SHALL cover: CLKS_POR_BIT = 2, char = 5'b00000 -> frame of 16 cycles with parity bit = 0.
